// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: ramps three 8-bit colour levels toward registered targets and drives glitch-free PWM LEDs.
// Define RGB_FADER_GAMMA_EN to pass each level through a square-law curve before the PWM compare.
module rgb_pwm_fader #(
  parameter int PWM_MAX = 254
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] red_target,
  input  logic [7:0] green_target,
  input  logic [7:0] blue_target,
  input  logic [3:0] rate,
  input  logic       fade_en,
  output logic [7:0] red_level,
  output logic [7:0] green_level,
  output logic [7:0] blue_level,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b,
  output logic       settled,
  output logic       frame_tick
);
  localparam logic [7:0] CNT_LAST = 8'(PWM_MAX);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STEP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [3:0]      pcnt_q, pcnt_d;
  logic [2:0][7:0] tgt_q, tgt_d;
  logic [2:0][7:0] level_q, level_d;
  logic [2:0][7:0] duty;
  logic [2:0]      pwm_q, pwm_d;
  logic            settled_q, settled_d;
  logic            frame_tick_q, frame_tick_d;
  logic            wrap;
  logic            match;

  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt) return cur + 8'd1;
    if (cur > tgt) return cur - 8'd1;
    return cur;
  endfunction

`ifdef RGB_FADER_GAMMA_EN
  logic [2:0][15:0] gamma_prod;
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      gamma_prod[c] = {8'd0, level_q[c]} * ({8'd0, level_q[c]} + 16'd1);
      duty[c]       = gamma_prod[c][15:8];
    end
  end
`else
  assign duty = level_q;
`endif

  always_comb begin
    tgt_d   = {blue_target, green_target, red_target};
    wrap    = (cnt_q == CNT_LAST);
    cnt_d   = wrap ? 8'd0 : cnt_q + 8'd1;
    match   = (level_q == tgt_q);
    state_d = state_q;
    pcnt_d  = pcnt_q;
    level_d = level_q;
    if (!fade_en) begin
      state_d = ST_IDLE;
      pcnt_d  = '0;
      if (wrap) level_d = tgt_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pcnt_d = '0;
          if (!match) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          // The step lands on the wrap edge so the new level owns the whole next period;
          // the one-cycle STEP state that follows only re-arms the period counter.
          if (wrap) begin
            if (pcnt_q >= rate) begin
              state_d = ST_STEP;
              for (int c = 0; c < 3; c++) level_d[c] = step_toward(level_q[c], tgt_q[c]);
            end else begin
              pcnt_d = pcnt_q + 4'd1;
            end
          end
        end
        ST_STEP: begin
          pcnt_d  = '0;
          state_d = match ? ST_IDLE : ST_WAIT;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    for (int c = 0; c < 3; c++) pwm_d[c] = (cnt_q < duty[c]);
    settled_d    = match;
    frame_tick_d = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pcnt_q       <= '0;
      tgt_q        <= '0;
      level_q      <= '0;
      pwm_q        <= '0;
      settled_q    <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pcnt_q       <= pcnt_d;
      tgt_q        <= tgt_d;
      level_q      <= level_d;
      pwm_q        <= pwm_d;
      settled_q    <= settled_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign red_level   = level_q[0];
  assign green_level = level_q[1];
  assign blue_level  = level_q[2];
  assign pwm_r       = pwm_q[0];
  assign pwm_g       = pwm_q[1];
  assign pwm_b       = pwm_q[2];
  assign settled     = settled_q;
  assign frame_tick  = frame_tick_q;
endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Bench for rgb_pwm_fader: a period-level model predicts levels at each wrap, a monitor checks them per frame.
module tb_rgb_pwm_fader;
  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic [7:0] red_target, green_target, blue_target;
  logic [3:0] rate;
  logic       fade_en;
  logic [7:0] red_level, green_level, blue_level;
  logic       pwm_r, pwm_g, pwm_b, settled, frame_tick;

  rgb_pwm_fader #(.PWM_MAX(254)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .red_target(red_target), .green_target(green_target), .blue_target(blue_target),
    .rate(rate), .fade_en(fade_en),
    .red_level(red_level), .green_level(green_level), .blue_level(blue_level),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
    .settled(settled), .frame_tick(frame_tick)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct packed {
    logic [2:0][7:0] lvl;
    logic            settled;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model, advanced once per PWM period.
  int              m_cnt;
  logic [2:0][7:0] m_lvl;
  int              m_wait;
  bit              m_active;

  // Monitor state.
  int   hi [3];
  bit   have_prev, at_start, chk_settled;
  exp_t cur;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int duty_of(input logic [7:0] l);
`ifdef RGB_FADER_GAMMA_EN
    return (int'(l) * (int'(l) + 1)) / 256;
`else
    return int'(l);
`endif
  endfunction

  function automatic int level_of(input int ch);
    return (ch == 0) ? int'(red_level) : (ch == 1) ? int'(green_level) : int'(blue_level);
  endfunction

  // Evaluated on the wrap cycle; inputs only change mid-period, so they equal the registered targets.
  task automatic model_wrap();
    logic [2:0][7:0] t;
    exp_t            e;
    t = {blue_target, green_target, red_target};
    if (!fade_en) begin
      m_lvl    = t;
      m_active = 0;
      m_wait   = 0;
    end else begin
      if (!m_active && m_lvl != t) begin
        m_active = 1;
        m_wait   = 0;
      end
      if (m_active) begin
        if (m_wait >= int'(rate)) begin
          for (int c = 0; c < 3; c++) begin
            if (m_lvl[c] < t[c]) m_lvl[c] = m_lvl[c] + 8'd1;
            else if (m_lvl[c] > t[c]) m_lvl[c] = m_lvl[c] - 8'd1;
          end
          m_wait = 0;
          if (m_lvl == t) m_active = 0;
        end else begin
          m_wait++;
        end
      end
    end
    e.lvl     = m_lvl;
    e.settled = (m_lvl == t);
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_cnt    = 0;
    m_lvl    = '0;
    m_wait   = 0;
    m_active = 0;
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
    m_cnt = (m_cnt == 254) ? 0 : m_cnt + 1;
    if (m_cnt == 254) begin
      check("frame_tick_at_wrap", frame_tick, 1);
      model_wrap();
    end else if (m_cnt == 100) begin
      check("frame_tick_mid_period", frame_tick, 0);
    end
  endtask

  task automatic goto_cnt(input int n);
    while (m_cnt != n) tick();
  endtask

  task automatic run_periods(input int n);
    for (int i = 0; i < n * 255; i++) tick();
  endtask

  task automatic run_until(input int ch, input logic [7:0] val, input int maxp);
    int p;
    p = 0;
    while (m_lvl[ch] != val && p < maxp) begin
      run_periods(1);
      p++;
    end
    check($sformatf("level_reached[%0d]", ch), level_of(ch), int'(val));
  endtask

  // Monitor: frame_tick marks the wrap; the following cycle is the period start.
  initial begin
    forever begin
      @(negedge clk_clk);
      if (!reset_reset_n) begin
        have_prev   = 0;
        at_start    = 0;
        chk_settled = 0;
        for (int c = 0; c < 3; c++) hi[c] = 0;
      end else begin
        if (pwm_r) hi[0]++;
        if (pwm_g) hi[1]++;
        if (pwm_b) hi[2]++;
        if (chk_settled) begin
          check("settled", settled, int'(cur.settled));
          chk_settled = 0;
        end
        if (at_start) begin
          at_start = 0;
          if (have_prev)
            for (int c = 0; c < 3; c++)
              check($sformatf("pwm_high_cycles[%0d]", c), hi[c], duty_of(cur.lvl[c]));
          for (int c = 0; c < 3; c++) hi[c] = 0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL frame_without_expected: expected queue size 0, required at least 1");
          end else begin
            cur = exp_q.pop_front();
            check("red_level", red_level, int'(cur.lvl[0]));
            check("green_level", green_level, int'(cur.lvl[1]));
            check("blue_level", blue_level, int'(cur.lvl[2]));
            have_prev   = 1;
            chk_settled = 1;
          end
        end
        if (frame_tick) at_start = 1;
      end
    end
  end

  logic [7:0] rows [3][3];

  initial begin
    rows[0] = '{8'h40, 8'hFF, 8'h00};
    rows[1] = '{8'h80, 8'h40, 8'hFF};
    rows[2] = '{8'hFF, 8'h00, 8'h40};
    reset_reset_n = 1'b0;
    red_target = 8'h80; green_target = 8'h80; blue_target = 8'h80;
    rate = 4'd0;
    fade_en = 1'b0;
    model_reset();

    // Reset values, then first snap to 0x80.
    repeat (4) @(posedge clk_clk);
    #1;
    check("reset_red_level", red_level, 0);
    check("reset_green_level", green_level, 0);
    check("reset_blue_level", blue_level, 0);
    check("reset_pwm", {pwm_r, pwm_g, pwm_b}, 0);
    check("reset_frame_tick", frame_tick, 0);
    check("reset_settled", settled, 1);
    reset_reset_n = 1'b1;
    goto_cnt(100);
    run_periods(2);

    // Snap duty patterns, including constant high and constant low.
    for (int r = 0; r < 3; r++) begin
      red_target = rows[r][0]; green_target = rows[r][1]; blue_target = rows[r][2];
      run_periods(2);
    end

    // Rate 0 fade on green 0 -> 3.
    fade_en = 1'b1;
    green_target = 8'h03;
    run_periods(5);

    // Rate 3 fade on blue 0x10 -> 0x20, reversed at 0x18.
    fade_en = 1'b0;
    blue_target = 8'h10;
    run_periods(1);
    fade_en = 1'b1;
    rate = 4'd3;
    blue_target = 8'h20;
    run_until(2, 8'h18, 40);
    blue_target = 8'h10;
    run_periods(13);

    // Red 0 -> 0xFF: reset mid-fade at 0x30.
    fade_en = 1'b0;
    rate = 4'd0;
    red_target = 8'h00;
    run_periods(1);
    fade_en = 1'b1;
    red_target = 8'hFF;
    run_until(0, 8'h30, 60);
    reset_reset_n = 1'b0;
    @(posedge clk_clk);
    #1;
    check("midfade_reset_red_level", red_level, 0);
    check("midfade_reset_settled", settled, 1);
    check("midfade_reset_pwm_r", pwm_r, 0);
    check("midfade_reset_frame_tick", frame_tick, 0);
    exp_q.delete();
    repeat (2) @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    model_reset();
    goto_cnt(100);

    // Same fade again, then drop fade_en at 0x30: snaps to 0xFF.
    run_until(0, 8'h30, 60);
    fade_en = 1'b0;
    run_periods(2);

    // Randomised targets, rates and mode changes, always mid-period.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) != 0) red_target   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) != 0) green_target = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) != 0) blue_target  = 8'($urandom_range(0, 255));
      rate    = 4'($urandom_range(0, 2));
      fade_en = ($urandom_range(0, 3) != 0);
      run_periods(int'($urandom_range(1, 3)));
    end

    check("expected_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
